// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: bus widths,
// FSM state encoding and tag-width helper.
package inst_cache_pkg;

    localparam int InstBusW     = 32;
    localparam int InstAddrBusW = 32;
    localparam logic [InstBusW-1:0] ZeroWord = '0;

    localparam int IcIndexW = 6;

    typedef enum logic {
        IcIdle   = 1'b0,
        IcRefill = 1'b1
    } ic_state_e;

    // Tag is what remains above the index and the byte offset.
    function automatic int ic_tag_w(input int addr_w, input int index_w);
        return addr_w - index_w - 2;
    endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data flop arrays with a combinational read port,
// one write port and a global valid clear.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int INDEX_W = IcIndexW,
    parameter int TAG_W   = ic_tag_w(InstAddrBusW, IcIndexW),
    parameter int DATA_W  = InstBusW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic [INDEX_W-1:0] ridx_i,
    output logic               rvalid_o,
    output logic [TAG_W-1:0]   rtag_o,
    output logic [DATA_W-1:0]  rdata_o,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] widx_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic               wvalid_i
);

    localparam int Lines = 1 << INDEX_W;

    logic [Lines-1:0]  valid_q;
    logic [Lines-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [Lines];
    logic [DATA_W-1:0] data_q [Lines];

    // Clear overrides a same-cycle write so a flush always wins.
    always_comb begin
        valid_d = valid_q;
        if (we_i) begin
            valid_d[widx_i] = wvalid_i;
        end
        if (clear_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: combinational hits, stalled
// refill of one word over a req/ack bus.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_W = IcIndexW,
    parameter int ADDR_W  = InstAddrBusW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [InstBusW-1:0] inst_o,
    output logic                stallreq_o,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic [InstBusW-1:0] mem_rdata_i,
    input  logic                mem_ack_i
);

    localparam int TagW = ic_tag_w(ADDR_W, INDEX_W);
    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

    ic_state_e         state_q;
    ic_state_e         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              drop_q;
    logic              drop_d;

    logic [INDEX_W-1:0]  idx;
    logic [TagW-1:0]     tag;
    logic                rvalid;
    logic [TagW-1:0]     rtag;
    logic [InstBusW-1:0] rdata;
    logic                hit;
    logic                we;
    logic                wvalid;

    assign idx = addr_i[INDEX_W+1:2];
    assign tag = addr_i[ADDR_W-1:INDEX_W+2];
    assign hit = ce_i & rvalid & (rtag == tag);

    // A flush seen at any point of the refill leaves the line invalid.
    assign wvalid = ~(drop_q | flush_i);

    inst_cache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TagW),
        .DATA_W  (InstBusW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (flush_i),
        .ridx_i   (idx),
        .rvalid_o (rvalid),
        .rtag_o   (rtag),
        .rdata_o  (rdata),
        .we_i     (we),
        .widx_i   (addr_q[INDEX_W+1:2]),
        .wtag_i   (addr_q[ADDR_W-1:INDEX_W+2]),
        .wdata_i  (mem_rdata_i),
        .wvalid_i (wvalid)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        drop_d     = drop_q;
        inst_o     = ZeroWord;
        stallreq_o = 1'b0;
        we         = 1'b0;
        case (state_q)
            IcIdle: begin
                if (hit) begin
                    inst_o = rdata;
                end else if (ce_i) begin
                    stallreq_o = 1'b1;
                    state_d    = IcRefill;
                    addr_d     = addr_i & AlignMask;
                    drop_d     = 1'b0;
                end
            end
            IcRefill: begin
                stallreq_o = 1'b1;
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_ack_i) begin
                    we      = 1'b1;
                    state_d = IcIdle;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = IcIdle;
            end
        endcase
        if (rst) begin
            inst_o     = ZeroWord;
            stallreq_o = 1'b0;
            we         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IcIdle;
            addr_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    assign mem_req_o  = (state_q == IcRefill) & ~rst;
    assign mem_addr_o = addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed vector table
// followed by random traffic against a line-array model.
module tb_inst_cache;

    localparam int IW = 6;
    localparam int AW = 32;
    localparam int NL = 1 << IW;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic        stall;
    logic        req;
    logic [31:0] maddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_cache #(
        .INDEX_W (IW),
        .ADDR_W  (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce),
        .addr_i      (addr),
        .inst_o      (inst),
        .stallreq_o  (stall),
        .flush_i     (flush),
        .mem_req_o   (req),
        .mem_addr_o  (maddr),
        .mem_rdata_i (rdata),
        .mem_ack_i   (ack)
    );

    typedef struct {
        logic        rst;
        logic        ce;
        logic [31:0] addr;
        logic        flush;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] e_inst;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(
        input logic r, input logic c, input logic [31:0] a,
        input logic f, input logic k, input logic [31:0] d,
        input logic [31:0] ei, input logic es, input logic er,
        input logic [31:0] em);
        vec_t v;
        v.rst = r; v.ce = c; v.addr = a;
        v.flush = f; v.ack = k; v.rdata = d;
        v.e_inst = ei; v.e_stall = es;
        v.e_req = er; v.e_maddr = em;
        return v;
    endfunction

    // Reference: per-line contents plus one outstanding bus transaction.
    bit          m_v [NL];
    logic [23:0] m_t [NL];
    logic [31:0] m_d [NL];
    bit          m_busy = 0;
    bit          m_drop = 0;
    logic [31:0] m_addr = 0;

    always @(posedge clk) begin
        int i;
        if (rst) begin
            foreach (m_v[j]) m_v[j] = 0;
            m_busy = 0;
            m_drop = 0;
            m_addr = 0;
        end else begin
            i = int'(addr[7:2]);
            if (m_busy) begin
                if (flush) m_drop = 1;
                if (ack) begin
                    i = int'(m_addr[7:2]);
                    m_t[i] = m_addr[31:8];
                    m_d[i] = rdata;
                    m_v[i] = !m_drop;
                    m_busy = 0;
                    m_drop = 0;
                end
            end else if (ce && !(m_v[i] && m_t[i] == addr[31:8])) begin
                m_busy = 1;
                m_addr = {addr[31:2], 2'b00};
            end
            if (flush) foreach (m_v[j]) m_v[j] = 0;
        end
    end

    task automatic model_exp(output logic [31:0] ei, output logic es,
                             output logic er, output logic [31:0] em);
        int i;
        bit h;
        i  = int'(addr[7:2]);
        h  = ce && m_v[i] && (m_t[i] == addr[31:8]);
        em = m_addr;
        ei = 0; es = 0; er = 0;
        if (!rst) begin
            if (m_busy) begin
                es = 1; er = 1;
            end else begin
                ei = h ? m_d[i] : 32'h0;
                es = ce && !h;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] ei,
                         input logic es, input logic er,
                         input logic [31:0] em);
        checks++;
        if (inst !== ei || stall !== es || req !== er || maddr !== em) begin
            errors++;
            $display("FAIL %s t=%0t inst=%h/%h stall=%b/%b req=%b/%b maddr=%h/%h",
                     nm, $time, inst, ei, stall, es, req, er, maddr, em);
        end
    endtask

    initial begin
        logic [31:0] ei;
        logic [31:0] em;
        logic        es;
        logic        er;
        logic [23:0] tg;

        rst = 1; ce = 0; addr = 0; flush = 0; ack = 0; rdata = 0;
        repeat (2) @(posedge clk);

        // rst ce addr flush ack rdata | inst stall req maddr
        tbl[0]  = mk(1,1,32'h100,0,0,0, 0,0,0,32'h0);
        tbl[1]  = mk(0,1,32'h100,0,0,0, 0,1,0,32'h0);
        tbl[2]  = mk(0,1,32'h100,0,0,0, 0,1,1,32'h100);
        tbl[3]  = mk(0,1,32'h100,0,0,0, 0,1,1,32'h100);
        tbl[4]  = mk(0,1,32'h100,0,1,32'h34011100, 0,1,1,32'h100);
        tbl[5]  = mk(0,1,32'h100,0,0,0, 32'h34011100,0,0,32'h100);
        tbl[6]  = mk(0,1,32'h101,0,0,0, 32'h34011100,0,0,32'h100);
        tbl[7]  = mk(0,0,32'h100,0,0,0, 0,0,0,32'h100);
        tbl[8]  = mk(0,0,32'h200,0,0,0, 0,0,0,32'h100);
        tbl[9]  = mk(0,1,32'h200,0,0,0, 0,1,0,32'h100);
        tbl[10] = mk(0,1,32'h200,0,1,32'hDEADBEEF, 0,1,1,32'h200);
        tbl[11] = mk(0,1,32'h200,0,0,0, 32'hDEADBEEF,0,0,32'h200);
        tbl[12] = mk(0,1,32'h100,0,0,0, 0,1,0,32'h200);
        tbl[13] = mk(0,1,32'h100,0,1,32'h34011100, 0,1,1,32'h100);
        tbl[14] = mk(0,1,32'h100,0,0,0, 32'h34011100,0,0,32'h100);
        tbl[15] = mk(0,1,32'h100,1,0,0, 32'h34011100,0,0,32'h100);
        tbl[16] = mk(0,1,32'h100,0,0,0, 0,1,0,32'h100);
        tbl[17] = mk(0,1,32'h100,1,0,0, 0,1,1,32'h100);
        tbl[18] = mk(0,1,32'h100,0,1,32'h11112222, 0,1,1,32'h100);
        tbl[19] = mk(0,1,32'h100,0,0,0, 0,1,0,32'h100);
        tbl[20] = mk(0,1,32'h100,1,1,32'h33334444, 0,1,1,32'h100);
        tbl[21] = mk(0,1,32'h100,0,0,0, 0,1,0,32'h100);
        tbl[22] = mk(1,1,32'h100,0,0,0, 0,0,0,32'h100);
        tbl[23] = mk(0,0,32'h100,0,1,32'h55556666, 0,0,0,32'h0);
        tbl[24] = mk(0,1,32'h100,0,0,0, 0,1,0,32'h0);
        tbl[25] = mk(0,1,32'h100,0,1,32'h34011100, 0,1,1,32'h100);
        tbl[26] = mk(0,1,32'h100,0,0,0, 32'h34011100,0,0,32'h100);

        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            rst = tbl[i].rst; ce = tbl[i].ce; addr = tbl[i].addr;
            flush = tbl[i].flush; ack = tbl[i].ack; rdata = tbl[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].e_inst,
                  tbl[i].e_stall, tbl[i].e_req, tbl[i].e_maddr);
        end

        // Reset mid-refill: request drops after the edge, late ack ignored.
        @(posedge clk); #1;
        rst = 0; ce = 1; addr = 32'h0000_0204; flush = 0; ack = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req", 0, 1, 1, 32'h204);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; ce = 0; ack = 1; rdata = 32'hCAFE0001;
        @(negedge clk);
        check("rst_drop", 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        ack = 0; ce = 1;
        @(negedge clk);
        check("late_ack", 0, 1, 0, 32'h0);

        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #1;
            rst   = ($urandom_range(0, 199) == 0);
            ce    = ($urandom_range(0, 7) != 0);
            tg    = 24'($urandom_range(0, 3)) * 24'h5A5A1;
            addr  = {tg, 3'b000, 3'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3))};
            flush = ($urandom_range(0, 39) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            rdata = $urandom;
            @(negedge clk);
            model_exp(ei, es, er, em);
            check("rand", ei, es, er, em);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
